score_max_ctrl: RTL and testbench

- Sequences a 64-lane, two-register-stage max-reduction tree over one Smith-Waterman alignment (many column beats).
- Keeps the running best score and writes it to a single-port result SRAM at an auto-incrementing index.
- Presents the score on a valid/ready result port.
- Sits between the PE array score outputs and the result memory / host readout.

---
 rtl/score_max_ctrl_if.sv | 30 +++
 rtl/score_max_ctrl.sv | 144 ++++++++++++++
 tb/tb_score_max_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/score_max_ctrl_if.sv
// Beat input, result SRAM and result handshake bundle for score_max_ctrl.
// The slave modport is the controller's view; master is the PE array / host side.
interface score_max_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LANES      = 64,
  parameter int unsigned ADDR_WIDTH = 10
);
  logic                        cell_valid;
  logic                        cell_ready;
  logic                        cell_last;
  logic [DATA_WIDTH*LANES-1:0] cell_score;
  logic                        mem_cen;
  logic                        mem_wen;
  logic [ADDR_WIDTH-1:0]       mem_addr;
  logic [DATA_WIDTH-1:0]       mem_data;
  logic                        best_valid;
  logic                        best_ready;
  logic [DATA_WIDTH-1:0]       best_score;
  logic [ADDR_WIDTH-1:0]       best_idx;

  modport master (
    output cell_valid, cell_last, cell_score, best_ready,
    input  cell_ready, mem_cen, mem_wen, mem_addr, mem_data, best_valid, best_score, best_idx
  );

  modport slave (
    input  cell_valid, cell_last, cell_score, best_ready,
    output cell_ready, mem_cen, mem_wen, mem_addr, mem_data, best_valid, best_score, best_idx
  );
endinterface

// File: rtl/score_max_ctrl.sv
// Smith-Waterman alignment max: 8x8 two-stage reduction tree, running best score,
// one SRAM write per alignment at an auto-incrementing index, then a result handshake.
`ifndef V_E_F_Bit
`define V_E_F_Bit 16
`endif

module score_max_ctrl #(
  parameter int unsigned DATA_WIDTH = `V_E_F_Bit,
  parameter int unsigned LANES      = 64,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            addr_clr,
  score_max_ctrl_if.slave bus
);
  localparam int unsigned Groups     = 8;
  localparam int unsigned GroupLanes = LANES / Groups;

  typedef enum logic [2:0] {StIdle, StAccum, StDrain, StWrite, StResult} state_e;

  state_e                            state_q, state_d;
  logic [1:0]                        cnt_q, cnt_d;
  logic [Groups-1:0][DATA_WIDTH-1:0] stage1_q, stage1_d;
  logic [DATA_WIDTH-1:0]             stage2_q, stage2_d;
  logic                              tag1_q, tag2_q, tag2_d;
  logic [DATA_WIDTH-1:0]             run_max_q, run_max_d;
  logic [ADDR_WIDTH-1:0]             idx_q, idx_d;
  logic [ADDR_WIDTH-1:0]             mem_addr_q, best_idx_q;
  logic [DATA_WIDTH-1:0]             mem_data_q, best_score_q;
  logic                              accept, clr_run, in_write;

  // Sign-aware max that never yields a negative value (two negatives give 0).
  function automatic logic [DATA_WIDTH-1:0] smax(input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
    logic a_neg, b_neg;
    a_neg = a[DATA_WIDTH-1];
    b_neg = b[DATA_WIDTH-1];
    if (a_neg && b_neg) return '0;
    else if (a_neg) return b;
    else if (b_neg) return a;
    else if (a[DATA_WIDTH-2:0] >= b[DATA_WIDTH-2:0]) return a;
    else return b;
  endfunction

  assign accept   = bus.cell_valid && (state_q == StAccum);
  assign in_write = (state_q == StWrite);

  always_comb begin
    stage1_d = '0;
    stage2_d = '0;
    for (int unsigned g = 0; g < Groups; g++) begin
      for (int unsigned l = 0; l < GroupLanes; l++) begin
        stage1_d[g] = smax(stage1_d[g], bus.cell_score[DATA_WIDTH*(g*GroupLanes+l) +: DATA_WIDTH]);
      end
      stage2_d = smax(stage2_d, stage1_q[g]);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    clr_run = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (addr_clr) idx_d = '0;
        if (start) begin
          clr_run = 1'b1;
          state_d = StAccum;
        end
      end
      StAccum: begin
        if (accept && bus.cell_last) begin
          state_d = StDrain;
          cnt_d   = 2'd2;
        end
      end
      StDrain: begin
        // Two cycles let the last beat walk through stage2 into the running max.
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1) state_d = StWrite;
      end
      StWrite: state_d = StResult;
      StResult: begin
        if (bus.best_ready) begin
          idx_d   = idx_q + ADDR_WIDTH'(1);
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign tag2_d = clr_run ? 1'b0 : tag1_q;

  always_comb begin
    run_max_d = run_max_q;
    if (clr_run) run_max_d = '0;
    else if (tag2_q) run_max_d = smax(run_max_q, stage2_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      stage1_q     <= '0;
      stage2_q     <= '0;
      tag1_q       <= 1'b0;
      tag2_q       <= 1'b0;
      run_max_q    <= '0;
      idx_q        <= '0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      best_score_q <= '0;
      best_idx_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tag1_q    <= accept;
      tag2_q    <= tag2_d;
      stage2_q  <= stage2_d;
      run_max_q <= run_max_d;
      idx_q     <= idx_d;
      if (accept) stage1_q <= stage1_d;
      if (in_write) begin
        mem_addr_q   <= idx_q;
        mem_data_q   <= run_max_q;
        best_score_q <= run_max_q;
        best_idx_q   <= idx_q;
      end
    end
  end

  assign bus.cell_ready = (state_q == StAccum);
  assign bus.mem_cen    = ~in_write;
  assign bus.mem_wen    = ~in_write;
  assign bus.mem_addr   = in_write ? idx_q : mem_addr_q;
  assign bus.mem_data   = in_write ? run_max_q : mem_data_q;
  assign bus.best_valid = (state_q == StResult);
  assign bus.best_score = best_score_q;
  assign bus.best_idx   = best_idx_q;
endmodule

// File: tb/tb_score_max_ctrl.sv
// Directed bench for score_max_ctrl: a cycle-level reference model drives expectations
// for every cycle, with literal checks pinning each alignment's result.
module tb_score_max_ctrl;
  localparam int W  = 16;
  localparam int L  = 64;
  localparam int AW = 10;
  typedef logic [W*L-1:0] beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic addr_clr = 1'b0;

  score_max_ctrl_if #(.DATA_WIDTH(W), .LANES(L), .ADDR_WIDTH(AW)) bus ();

  score_max_ctrl #(.DATA_WIDTH(W), .LANES(L), .ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .addr_clr (addr_clr),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int           cyc = 0;
  int           n_chk = 0;
  int           n_fail = 0;
  int           wr_cyc = -100;
  int           exp_idx = 0;
  bit           res_pending = 1'b0;
  bit           exp_ready = 1'b0;
  bit           chk_en = 1'b0;
  logic [W-1:0] exp_max = '0;
  beat_t        beats [4];
  bit           gap [4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Largest non-negative lane value, or 0 when every lane is negative.
  function automatic logic [W-1:0] beat_max(input beat_t v);
    int m, x;
    m = 0;
    for (int i = 0; i < L; i++) begin
      x = int'(v[W*i +: W]);
      if (x < (1 << (W - 1)) && x > m) m = x;
    end
    return W'(m);
  endfunction

  function automatic beat_t fill(input logic [W-1:0] v);
    beat_t r;
    for (int i = 0; i < L; i++) r[W*i +: W] = v;
    return r;
  endfunction

  always @(negedge clk) begin
    bit wr, bv;
    if (chk_en && !rst) begin
      wr = (cyc == wr_cyc);
      bv = res_pending && (cyc > wr_cyc);
      check("cell_ready", 32'(bus.cell_ready), 32'(exp_ready));
      check("mem_cen", 32'(bus.mem_cen), 32'(!wr));
      check("mem_wen", 32'(bus.mem_wen), 32'(!wr));
      if (wr) begin
        check("mem_addr", 32'(bus.mem_addr), 32'(exp_idx));
        check("mem_data", 32'(bus.mem_data), 32'(exp_max));
      end
      check("best_valid", 32'(bus.best_valid), 32'(bv));
      if (bv) begin
        check("best_score", 32'(bus.best_score), 32'(exp_max));
        check("best_idx", 32'(bus.best_idx), 32'(exp_idx));
      end
    end
  end

  task automatic run_align(input int nb, input int hold, input int lit_score, input int lit_idx,
                           input bit clr);
    start    = 1'b1;
    addr_clr = clr;
    exp_max  = '0;
    if (clr) exp_idx = 0;
    @(posedge clk); #1;
    start     = 1'b0;
    addr_clr  = 1'b0;
    exp_ready = 1'b1;
    for (int b = 0; b < nb; b++) begin
      bus.cell_valid = 1'b1;
      bus.cell_score = beats[b];
      bus.cell_last  = (b == nb - 1);
      if (beat_max(beats[b]) > exp_max) exp_max = beat_max(beats[b]);
      if (b == nb - 1) begin
        wr_cyc      = cyc + 3;
        res_pending = 1'b1;
      end
      @(posedge clk); #1;
      bus.cell_valid = 1'b0;
      bus.cell_last  = 1'b0;
      if (gap[b] && b != nb - 1) begin
        bus.cell_last = 1'b1;  // last without valid must be ignored
        @(posedge clk); #1;
        bus.cell_last = 1'b0;
      end
    end
    exp_ready = 1'b0;
    while (cyc < wr_cyc + 1) begin
      @(posedge clk); #1;
    end
    if (hold > 0) begin
      start = 1'b1;
      repeat (hold) begin
        @(posedge clk); #1;
      end
      start = 1'b0;
    end
    if (lit_score >= 0) begin
      check("lit_score", 32'(bus.best_score), 32'(lit_score));
      check("model_max", 32'(exp_max), 32'(lit_score));
    end
    if (lit_idx >= 0) check("lit_idx", 32'(bus.best_idx), 32'(lit_idx));
    bus.best_ready = 1'b1;
    @(posedge clk); #1;
    bus.best_ready = 1'b0;
    res_pending    = 1'b0;
    exp_idx        = (exp_idx + 1) % (1 << AW);
  endtask

  initial begin
    bus.cell_valid = 1'b0;
    bus.cell_last  = 1'b0;
    bus.cell_score = '0;
    bus.best_ready = 1'b0;
    for (int b = 0; b < 4; b++) gap[b] = 1'b0;
    #2;
    check("rst_cell_ready", 32'(bus.cell_ready), 32'd0);
    check("rst_best_valid", 32'(bus.best_valid), 32'd0);
    check("rst_mem_cen", 32'(bus.mem_cen), 32'd1);
    check("rst_mem_wen", 32'(bus.mem_wen), 32'd1);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_mem_data", 32'(bus.mem_data), 32'd0);
    check("rst_best_score", 32'(bus.best_score), 32'd0);
    check("rst_best_idx", 32'(bus.best_idx), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst    = 1'b0;
    chk_en = 1'b1;
    @(posedge clk); #1;

    // Ramp 0..63 in one last beat, result held 10 cycles with start pulsed.
    for (int i = 0; i < L; i++) beats[0][W*i +: W] = W'(i);
    run_align(1, 10, 63, 0, 1'b0);

    // Three beats (10, 200, 45) with a bubble after the first.
    beats[0] = fill(16'd1);
    beats[0][W*5 +: W] = 16'd10;
    beats[1] = fill(16'd2);
    beats[1][W*40 +: W] = 16'd200;
    beats[2] = fill(16'd3);
    beats[2][W*63 +: W] = 16'd45;
    beats[2][0 +: W] = 16'h9000;
    gap[0] = 1'b1;
    run_align(3, 0, 200, 1, 1'b0);
    gap[0] = 1'b0;

    beats[0] = fill(16'hFFF0);
    run_align(1, 0, 0, 2, 1'b0);

    for (int i = 0; i < L; i++) beats[0][W*i +: W] = (i % 2 == 1) ? 16'h8005 : 16'h0003;
    run_align(1, 0, 3, 3, 1'b0);

    beats[0] = fill(16'd100);
    beats[0][W*3 +: W] = 16'hFFFF;
    beats[0][W*58 +: W] = 16'h7FFF;
    run_align(1, 0, 32767, 4, 1'b0);

    // addr_clr alone in IDLE after five alignments.
    addr_clr = 1'b1;
    @(posedge clk); #1;
    addr_clr = 1'b0;
    exp_idx  = 0;
    beats[0] = fill(16'd50);
    run_align(1, 0, 50, 0, 1'b0);

    // Full index sweep: writes 1..1023, then wraps to 0.
    for (int k = 0; k < (1 << AW); k++) begin
      for (int i = 0; i < L; i++) beats[0][W*i +: W] = W'($urandom);
      run_align(1, 0, -1, (k == 1022) ? 1023 : ((k == 1023) ? 0 : -1), 1'b0);
    end

    // Reset while draining aborts the alignment without a write.
    beats[0] = fill(16'd77);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_ready = 1'b1;
    bus.cell_valid = 1'b1;
    bus.cell_last  = 1'b1;
    bus.cell_score = beats[0];
    @(posedge clk); #1;
    bus.cell_valid = 1'b0;
    bus.cell_last  = 1'b0;
    #2;
    rst = 1'b1;
    exp_ready = 1'b0;
    res_pending = 1'b0;
    wr_cyc = -100;
    exp_idx = 0;
    #1;
    check("drain_rst_mem_cen", 32'(bus.mem_cen), 32'd1);
    check("drain_rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("drain_rst_mem_data", 32'(bus.mem_data), 32'd0);
    check("drain_rst_best_score", 32'(bus.best_score), 32'd0);
    check("drain_rst_best_idx", 32'(bus.best_idx), 32'd0);
    check("drain_rst_cell_ready", 32'(bus.cell_ready), 32'd0);
    @(posedge clk); #3;
    rst = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    beats[0] = fill(16'd3);
    beats[0][W*10 +: W] = 16'd9;
    run_align(1, 0, 9, 0, 1'b1);
    repeat (3) begin
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
